// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv2d_stream_engine slice.
//   conv_state_e : controller state encoding
//   clog2_1      : address width that never collapses to zero bits
//   out_dim      : side length of a valid (unpadded) convolution output
// No ports (package).
package conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_MAC,
        S_EMIT,
        S_DONE
    } conv_state_e;

    function automatic int clog2_1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K x IMG_W circular row store for the convolution window.
// Ports:
//   clk              clock
//   wr_en            write strobe
//   wr_row, wr_col   write slot (buffer row, column)
//   wr_data          signed pixel to store
//   rd_row, rd_col   read slot (buffer row, column)
//   rd_data          signed pixel at the read slot (combinational read)
// Contents are not reset: every slot is written before it is read in a frame.
module conv_line_buffer #(
    parameter int DATA_W = 16,
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int BW     = 2,
    parameter int CW     = 3
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [BW-1:0]            wr_row,
    input  logic [CW-1:0]            wr_col,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [BW-1:0]            rd_row,
    input  logic [CW-1:0]            rd_col,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem_q [K][IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_row][rd_col];

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming valid (unpadded) KxK 2-D convolution with a single sequential MAC.
// Pixels arrive in raster order; the latest K rows live in a circular line
// buffer. Each window-completing pixel triggers K*K MAC cycles, then one
// result is offered on the output handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start / busy / done           frame control and status
//   kw_valid, kw_addr, kw_data    kernel coefficient write (IDLE only)
//   in_valid, in_ready, in_data   pixel stream
//   out_valid, out_ready,
//   out_data, out_last            result stream, out_last on final result
// Build option: RELU_EN -- when defined, negative results are emitted as 0.
//
// state | meaning
// IDLE  | waiting for start, kernel writes accepted
// FILL  | accepting pixels into the line buffer
// MAC   | K*K multiply-accumulate cycles for one window
// EMIT  | result held on out_data until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    localparam int KA_W   = clog2_1(K * K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     kw_valid,
    input  logic [KA_W-1:0]          kw_addr,
    input  logic signed [DATA_W-1:0] kw_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_last
);

    localparam int KK = K * K;
    localparam int RW = clog2_1(IMG_H);
    localparam int CW = clog2_1(IMG_W);
    localparam int BW = clog2_1(K);

    conv_state_e               state_q, state_d;
    logic [RW-1:0]             row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [BW-1:0]             brow_q, brow_d;
    logic [BW-1:0]             rd_brow_q, rd_brow_d;
    logic [CW-1:0]             rd_col_q, rd_col_d;
    logic [BW-1:0]             j_q, j_d;
    logic [KA_W-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      last_q, last_d;
    logic signed [DATA_W-1:0]  kern_q [KK];
    logic signed [DATA_W-1:0]  kern_d [KK];

    logic                      wr_en;
    logic signed [DATA_W-1:0]  rd_data;
    logic signed [2*DATA_W-1:0] prod;

    function automatic logic [BW-1:0] brow_inc(input logic [BW-1:0] b);
        return (b == BW'(K - 1)) ? '0 : b + BW'(1);
    endfunction

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .K      (K),
        .IMG_W  (IMG_W),
        .BW     (BW),
        .CW     (CW)
    ) u_line_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_row  (brow_q),
        .wr_col  (col_q),
        .wr_data (in_data),
        .rd_row  (rd_brow_q),
        .rd_col  (rd_col_q),
        .rd_data (rd_data)
    );

    // Operands are sign-extended before the multiply so the full-width product is exact.
    assign prod = (2*DATA_W)'(kern_q[k_q]) * (2*DATA_W)'(rd_data);

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        brow_d    = brow_q;
        rd_brow_d = rd_brow_q;
        rd_col_d  = rd_col_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        last_d    = last_q;
        kern_d    = kern_q;
        wr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (kw_valid && (int'(kw_addr) < KK)) begin
                    kern_d[kw_addr] = kw_data;
                end
                if (start) begin
                    state_d = S_FILL;
                    row_d   = '0;
                    col_d   = '0;
                    brow_d  = '0;
                    last_d  = 1'b0;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (col_q == CW'(IMG_W - 1)) begin
                        col_d  = '0;
                        row_d  = row_q + RW'(1);
                        brow_d = brow_inc(brow_q);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if ((row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1))) begin
                        // Oldest window row sits one slot after the row just written.
                        state_d   = S_MAC;
                        acc_d     = '0;
                        k_d       = '0;
                        j_d       = '0;
                        rd_brow_d = brow_inc(brow_q);
                        rd_col_d  = col_q - CW'(K - 1);
                        last_d    = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + KA_W'(1);
                if (j_q == BW'(K - 1)) begin
                    j_d       = '0;
                    rd_col_d  = rd_col_q - CW'(K - 1);
                    rd_brow_d = brow_inc(rd_brow_q);
                end else begin
                    j_d      = j_q + BW'(1);
                    rd_col_d = rd_col_q + CW'(1);
                end
                if (k_q == KA_W'(KK - 1)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    state_d = last_q ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            brow_q    <= '0;
            rd_brow_q <= '0;
            rd_col_q  <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            last_q    <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                kern_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            brow_q    <= brow_d;
            rd_brow_q <= rd_brow_d;
            rd_col_q  <= rd_col_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            last_q    <= last_d;
            kern_q    <= kern_d;
        end
    end

    assign busy      = (state_q == S_FILL) || (state_q == S_MAC) || (state_q == S_EMIT);
    assign done      = (state_q == S_DONE);
    assign in_ready  = (state_q == S_FILL);
    assign out_valid = (state_q == S_EMIT);
    assign out_last  = (state_q == S_EMIT) && last_q;

`ifdef RELU_EN
    assign out_data = acc_q[ACC_W-1] ? '0 : acc_q;
`else
    assign out_data = acc_q;
`endif

endmodule

// File: tb/tb_conv2d_stream_engine.sv
module tb_conv2d_stream_engine;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int KK     = K * K;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int NOUT   = OW * OH;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int KA_W   = $clog2(KK);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     kw_valid;
    logic [KA_W-1:0]          kw_addr;
    logic signed [DATA_W-1:0] kw_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_last;

    int checks = 0;
    int errors = 0;

    logic signed [DATA_W-1:0] img_m  [IMG_H][IMG_W];
    logic signed [DATA_W-1:0] kern_m [KK];
    logic signed [ACC_W-1:0]  exp_q  [$];

    always #5 clk = ~clk;

    conv2d_stream_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .kw_valid  (kw_valid),
        .kw_addr   (kw_addr),
        .kw_data   (kw_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: direct sum over each valid window position.
    task automatic build_expected();
        longint s;
        exp_q.delete();
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                s = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        s += longint'(kern_m[i*K+j]) * longint'(img_m[r+i][c+j]);
`ifdef RELU_EN
                if (s < 0) s = 0;
`endif
                exp_q.push_back(ACC_W'(s));
            end
        end
    endtask

    task automatic ramp_image();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img_m[r][c] = DATA_W'(8*r + c);
    endtask

    task automatic kw_write(input int a, input int d);
        @(negedge clk);
        kw_valid = 1'b1;
        kw_addr  = KA_W'(a);
        kw_data  = DATA_W'(d);
        @(negedge clk);
        kw_valid = 1'b0;
    endtask

    task automatic load_kernel();
        for (int i = 0; i < KK; i++) kw_write(i, int'(kern_m[i]));
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_in_ready"}, in_ready, 0);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_data"}, out_data, 0);
        chk({pfx, "_out_last"}, out_last, 0);
    endtask

    // Runs one frame; returns at a negedge. abort_after>0 stops after that many pixels.
    task automatic run_frame(input int gap_pct, input int rdy_pct, input int stall_first,
                             input int abort_after, input bit kw_busy);
        int idx, oidx, cyc, t_comp, done_cnt, stall;
        bit in_fire, out_fire, prev_ov;
        idx = 0; oidx = 0; cyc = 0; t_comp = 0; done_cnt = 0; stall = 0;
        prev_ov = 1'b0;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (oidx < NOUT && cyc < 5000) begin
            if (abort_after > 0 && idx == abort_after) break;
            if (out_valid) begin
                if (!prev_ov) chk("latency", cyc - t_comp, KK + 1);
                chk("out_data", out_data, exp_q[oidx]);
                chk("out_last", out_last, oidx == NOUT - 1);
                chk("in_ready_in_emit", in_ready, 0);
            end
            prev_ov = out_valid;
            in_valid = (idx < NPIX) && ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? img_m[idx / IMG_W][idx % IMG_W] : DATA_W'($urandom);
            if (oidx == 0 && stall < stall_first) begin
                out_ready = 1'b0;
                if (out_valid) stall++;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
            end
            kw_valid = kw_busy && (cyc == 3 || cyc == 40);
            kw_addr  = KA_W'(4);
            kw_data  = DATA_W'(7);
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            done_cnt += int'(done);
            @(negedge clk);
            cyc++;
            if (in_fire) begin
                if ((idx / IMG_W) >= K - 1 && (idx % IMG_W) >= K - 1) t_comp = cyc - 1;
                idx++;
            end
            if (out_fire) oidx++;
        end
        in_valid  = 1'b0;
        kw_valid  = 1'b0;
        out_ready = 1'b0;
        if (abort_after > 0) return;
        if (cyc >= 5000) begin
            chk("frame_timeout_outputs", oidx, NOUT);
        end else begin
            repeat (4) begin
                done_cnt += int'(done);
                @(negedge clk);
            end
            chk("done_pulses", done_cnt, 1);
            chk("busy_after_frame", busy, 0);
            chk("pixels_consumed", idx, NPIX);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kw_valid = 1'b0; kw_addr = '0; kw_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // All-ones kernel over the ramp image.
        ramp_image();
        for (int i = 0; i < KK; i++) kern_m[i] = 1;
        build_expected();
        chk("model_first", exp_q[0], 81);
        chk("model_last", exp_q[NOUT-1], 486);
        load_kernel();
        run_frame(0, 100, 0, 0, 1'b0);

        // Vertical gradient kernels: +48 everywhere, then -48 (0 with RELU_EN).
        for (int i = 0; i < KK; i++) kern_m[i] = DATA_W'(i / K - 1);
        load_kernel();
        run_frame(0, 100, 0, 0, 1'b0);
        for (int i = 0; i < KK; i++) kern_m[i] = DATA_W'(1 - i / K);
        load_kernel();
        run_frame(0, 100, 0, 0, 1'b0);

        // Downstream stall on the first result, then input gaps.
        for (int i = 0; i < KK; i++) kern_m[i] = 1;
        load_kernel();
        run_frame(0, 100, 5, 0, 1'b0);
        run_frame(50, 100, 0, 0, 1'b0);

        // Reset mid-frame clears outputs and kernel.
        run_frame(0, 100, 0, 20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midframe_rst");
        rst = 1'b0;
        for (int i = 0; i < KK; i++) kern_m[i] = 0;
        run_frame(0, 100, 0, 0, 1'b0);
        for (int i = 0; i < KK; i++) kern_m[i] = 1;
        load_kernel();
        run_frame(0, 100, 0, 0, 1'b0);

        // Kernel writes while busy are ignored; in IDLE they land; out-of-range ignored.
        run_frame(0, 100, 0, 0, 1'b1);
        kw_write(4, 7);
        kern_m[4] = 7;
        kw_write(9, 100);
        run_frame(0, 100, 0, 0, 1'b0);

        // Random image and kernel with random gaps and back-pressure.
        repeat (2) begin
            for (int r = 0; r < IMG_H; r++)
                for (int c = 0; c < IMG_W; c++)
                    img_m[r][c] = DATA_W'($urandom);
            for (int i = 0; i < KK; i++) kern_m[i] = DATA_W'($urandom);
            load_kernel();
            run_frame(50, 70, 0, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
